ex_stage: RTL and testbench

Execute stage of the St.PU five-stage pipeline. It sits directly downstream of the ID stage (via the ID/EX register) and computes:
- the register-file write result for logic, shift and arithmetic ops, plus MFHI/MFLO;
- HI/LO updates for MULT/MULTU/MTHI/MTLO/DIV/DIVU, with HI/LO forwarding from MEM and WB.

A sequential radix-2 divider raises `stallreq_o` while a division is in progress.

---
 rtl/ex_stage_if.sv | 37 +++
 rtl/ex_stage.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX and EX-to-EX/MEM signal bundle for the execute stage.
// master: the surrounding pipeline (drives operands, consumes results); slave: ex_stage.
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        mem_whilo_i;
    logic [31:0] mem_hi_i;
    logic [31:0] mem_lo_i;
    logic        wb_whilo_i;
    logic [31:0] wb_hi_i;
    logic [31:0] wb_lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: GPR results, HI/LO updates with MEM/WB forwarding, zero-cycle except divide.
// Define EX_DIV_EN to build the 32-step radix-2 divider; without it DIV/DIVU write nothing and never stall.
module ex_stage (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
    localparam logic [7:0] OP_ORI   = 8'b0101_1010;
    localparam logic [7:0] OP_XORI  = 8'b0101_1011;
    localparam logic [7:0] OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_SLTI  = 8'b0101_0111;
    localparam logic [7:0] OP_SLTIU = 8'b0101_1000;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    logic [7:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi_fwd, lo_fwd;
    logic [31:0] logic_res, shift_res, arith_res, move_res;
    logic [31:0] sum, diff;
    logic        ovf;
    logic [63:0] prod_s, prod_u;
    logic        is_div;
    logic        div_stall, div_wr;
    logic [31:0] div_hi, div_lo;

    assign op     = bus.aluop_i;
    assign a      = bus.reg1_i;
    assign b      = bus.reg2_i;
    assign sum    = a + b;
    assign diff   = a - b;
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // MEM holds the youngest HI/LO write, so it wins over WB.
    always_comb begin
        hi_fwd = bus.hi_i;
        lo_fwd = bus.lo_i;
        if (bus.mem_whilo_i) begin
            hi_fwd = bus.mem_hi_i;
            lo_fwd = bus.mem_lo_i;
        end else if (bus.wb_whilo_i) begin
            hi_fwd = bus.wb_hi_i;
            lo_fwd = bus.wb_lo_i;
        end
    end

    always_comb begin
        logic_res = 32'd0;
        case (op)
            OP_OR, OP_ORI, OP_LUI: logic_res = a | b;
            OP_AND, OP_ANDI:       logic_res = a & b;
            OP_XOR, OP_XORI:       logic_res = a ^ b;
            OP_NOR:                logic_res = ~(a | b);
            default:               logic_res = 32'd0;
        endcase
    end

    always_comb begin
        shift_res = 32'd0;
        case (op)
            OP_SLL:  shift_res = b << a[4:0];
            OP_SRL:  shift_res = b >> a[4:0];
            OP_SRA:  shift_res = $unsigned($signed(b) >>> a[4:0]);
            default: shift_res = 32'd0;
        endcase
    end

    always_comb begin
        arith_res = 32'd0;
        ovf       = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                arith_res = sum;
                ovf       = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_ADDU, OP_ADDIU: arith_res = sum;
            OP_SUB: begin
                arith_res = diff;
                ovf       = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_SUBU:           arith_res = diff;
            OP_SLT, OP_SLTI:   arith_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU, OP_SLTIU: arith_res = {31'd0, a < b};
            default:           arith_res = 32'd0;
        endcase
    end

    always_comb begin
        move_res = 32'd0;
        case (op)
            OP_MFHI: move_res = hi_fwd;
            OP_MFLO: move_res = lo_fwd;
            default: move_res = 32'd0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] quo, rem, dvsr;
    logic        neg_q, neg_r;
    logic        is_sdiv;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial, trial_sub;
    logic        fits;

    assign is_sdiv   = (op == OP_DIV);
    assign a_mag     = (is_sdiv && a[31]) ? 32'd0 - a : a;
    assign b_mag     = (is_sdiv && b[31]) ? 32'd0 - b : b;
    // quo doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign trial     = {rem, quo[31]};
    assign trial_sub = trial - {1'b0, dvsr};
    assign fits      = !trial_sub[32];

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (is_div) state_nxt = (b == 32'd0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (!is_div)             state_nxt = DIV_IDLE;
                else if (cnt == 6'd31)   state_nxt = DIV_DONE;
            end
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_stall = 1'b0;
        div_wr    = 1'b0;
        case (state)
            DIV_IDLE: div_stall = is_div;
            DIV_BUSY: div_stall = is_div;
            DIV_DONE: div_wr    = is_div;
            default:  div_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 6'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dvsr  <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && is_div) begin
            cnt <= 6'd0;
            if (b == 32'd0) begin
                quo   <= 32'hFFFF_FFFF;
                rem   <= a;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= a_mag;
                rem   <= 32'd0;
                dvsr  <= b_mag;
                neg_q <= is_sdiv && (a[31] ^ b[31]);
                neg_r <= is_sdiv && a[31];
            end
        end else if (state == DIV_BUSY && is_div) begin
            quo <= {quo[30:0], fits};
            rem <= fits ? trial_sub[31:0] : trial[31:0];
            cnt <= cnt + 6'd1;
        end
    end

    assign div_lo = neg_q ? 32'd0 - quo : quo;
    assign div_hi = neg_r ? 32'd0 - rem : rem;
`else
    wire unused_clk = clk;

    assign div_stall = 1'b0;
    assign div_wr    = 1'b0;
    assign div_lo    = 32'd0;
    assign div_hi    = 32'd0;
`endif

    always_comb begin
        bus.wd_o       = bus.wd_i;
        bus.wreg_o     = bus.wreg_i && !ovf;
        bus.wdata_o    = 32'd0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = 32'd0;
        bus.lo_o       = 32'd0;
        bus.stallreq_o = div_stall;
        case (bus.alusel_i)
            SEL_LOGIC: bus.wdata_o = logic_res;
            SEL_SHIFT: bus.wdata_o = shift_res;
            SEL_MOVE:  bus.wdata_o = move_res;
            SEL_ARITH: bus.wdata_o = arith_res;
            default:   bus.wdata_o = 32'd0;
        endcase
        case (op)
            OP_MTHI: begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = a;
                bus.lo_o    = lo_fwd;
            end
            OP_MTLO: begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = hi_fwd;
                bus.lo_o    = a;
            end
            OP_MULT: begin
                bus.whilo_o = 1'b1;
                {bus.hi_o, bus.lo_o} = prod_s;
            end
            OP_MULTU: begin
                bus.whilo_o = 1'b1;
                {bus.hi_o, bus.lo_o} = prod_u;
            end
            default: begin
                if (is_div && div_wr) begin
                    bus.whilo_o = 1'b1;
                    bus.hi_o    = div_hi;
                    bus.lo_o    = div_lo;
                end
            end
        endcase
        if (rst) begin
            bus.wd_o       = 5'd0;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = 32'd0;
            bus.whilo_o    = 1'b0;
            bus.hi_o       = 32'd0;
            bus.lo_o       = 32'd0;
            bus.stallreq_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
// Divider scenarios run only when EX_DIV_EN is defined; otherwise DIV/DIVU are checked as no-ops.
module tb_ex_stage;
    localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_ANDI = 8'h59, OP_ORI = 8'h5A, OP_XORI = 8'h5B, OP_LUI = 8'h5C;
    localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
    localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
    localparam logic [7:0] OP_SLT = 8'h2A, OP_SLTU = 8'h2B, OP_SLTI = 8'h57, OP_SLTIU = 8'h58;
    localparam logic [7:0] OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_SUB = 8'h22, OP_SUBU = 8'h23;
    localparam logic [7:0] OP_ADDI = 8'h55, OP_ADDIU = 8'h56;
    localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_BAD = 8'hEE;
    localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_MOV = 3'd3, S_AR = 3'd4;
    localparam int NOPS = 28;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic [7:0] op_tab [NOPS] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_ADDI, OP_ADDIU,
        OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_MULT, OP_MULTU, OP_BAD};
    logic [2:0] sel_tab [NOPS] = '{S_LOG, S_LOG, S_LOG, S_LOG, S_LOG, S_LOG, S_LOG, S_LOG,
        S_SH, S_SH, S_SH, S_AR, S_AR, S_AR, S_AR, S_AR, S_AR,
        S_AR, S_AR, S_AR, S_AR, S_MOV, S_MOV, S_NOP, S_NOP,
        S_NOP, S_NOP, S_LOG};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    // Spec-level behaviour: plain 64-bit arithmetic, HI/LO already forwarded by the caller.
    function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic wreg_in, input logic [31:0] hif, input logic [31:0] lof,
                                  output logic [31:0] wdata, output logic wreg, output logic whilo,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          r;
        logic [63:0]     p;
        wdata = 32'd0; wreg = wreg_in; whilo = 1'b0; hi = 32'd0; lo = 32'd0;
        case (op)
            OP_OR, OP_ORI, OP_LUI: wdata = a | b;
            OP_AND, OP_ANDI:       wdata = a & b;
            OP_XOR, OP_XORI:       wdata = a ^ b;
            OP_NOR:                wdata = ~(a | b);
            OP_SLL:                wdata = 32'(ub << a[4:0]);
            OP_SRL:                wdata = 32'(ub >> a[4:0]);
            OP_SRA:                wdata = 32'(sb >>> a[4:0]);
            OP_ADD, OP_ADDI: begin
                r = sa + sb; wdata = 32'(r);
                if (r > MAXS || r < MINS) wreg = 1'b0;
            end
            OP_SUB: begin
                r = sa - sb; wdata = 32'(r);
                if (r > MAXS || r < MINS) wreg = 1'b0;
            end
            OP_ADDU, OP_ADDIU:     wdata = 32'(ua + ub);
            OP_SUBU:               wdata = 32'(ua - ub);
            OP_SLT, OP_SLTI:       wdata = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU:     wdata = (ua < ub) ? 32'd1 : 32'd0;
            OP_MFHI:               wdata = hif;
            OP_MFLO:               wdata = lof;
            OP_MTHI: begin whilo = 1'b1; hi = a;   lo = lof; end
            OP_MTLO: begin whilo = 1'b1; hi = hif; lo = a;   end
            OP_MULT: begin
                p = 64'(sa * sb); whilo = 1'b1; hi = p[63:32]; lo = p[31:0];
            end
            OP_MULTU: begin
                p = 64'(ua * ub); whilo = 1'b1; hi = p[63:32]; lo = p[31:0];
            end
            default: ;
        endcase
    endfunction

    function automatic void div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn) begin
            q = 32'(sa / sb); r = 32'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'(1);
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = a; bus.reg2_i = b;
    endtask

    // Presents a divide right after a clock edge and waits for the result cycle.
    task automatic issue_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int stalls, output bit done, output logic wh,
                             output logic [31:0] hi, output logic [31:0] lo);
        @(posedge clk); #1;
        drive(op, S_NOP, a, b);
        stalls = 0; done = 1'b0; wh = 1'b0; hi = 32'd0; lo = 32'd0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.stallreq_o) stalls++;
            else begin done = 1'b1; wh = bus.whilo_o; hi = bus.hi_o; lo = bus.lo_o; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wd_i = 5'd9; bus.wreg_i = 1'b1; bus.mem_whilo_i = 1'b1; bus.mem_hi_i = 32'h1234;
        drive(OP_ADD, S_AR, 32'd3, 32'd4);
        @(negedge clk);
        checks++; if (bus.wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata_o); end
        checks++; if (bus.wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got=%b exp=0", bus.wreg_o); end
        checks++; if (bus.wd_o !== 5'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", bus.wd_o); end
        drive(OP_MULT, S_NOP, 32'd5, 32'd6);
        @(negedge clk);
        checks++; if ({bus.whilo_o, bus.hi_o, bus.lo_o} !== 65'd0) begin errors++; $display("FAIL reset_hilo got=%b/%h/%h exp=0", bus.whilo_o, bus.hi_o, bus.lo_o); end
        drive(OP_DIV, S_NOP, 32'd7, 32'd2);
        @(negedge clk);
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stallreq_o); end
        drive(8'd0, S_NOP, 32'd0, 32'd0);
        bus.mem_whilo_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        bus.wreg_i = 1'b1; bus.wd_i = 5'd3;
        drive(OP_ADD, S_AR, 32'h7FFF_FFFF, 32'd1); @(negedge clk);
        checks++; if (bus.wdata_o !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_wdata got=%h exp=80000000", bus.wdata_o); end
        checks++; if (bus.wreg_o !== 1'b0) begin errors++; $display("FAIL add_ovf_wreg got=%b exp=0", bus.wreg_o); end
        drive(OP_ADDU, S_AR, 32'h7FFF_FFFF, 32'd1); @(negedge clk);
        checks++; if (bus.wreg_o !== 1'b1) begin errors++; $display("FAIL addu_wreg got=%b exp=1", bus.wreg_o); end
        drive(OP_SRA, S_SH, 32'd4, 32'h8000_0000); @(negedge clk);
        checks++; if (bus.wdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra got=%h exp=f8000000", bus.wdata_o); end
        drive(OP_SLTU, S_AR, 32'd1, 32'hFFFF_FFFF); @(negedge clk);
        checks++; if (bus.wdata_o !== 32'd1) begin errors++; $display("FAIL sltu got=%h exp=1", bus.wdata_o); end
        drive(OP_SLT, S_AR, 32'd1, 32'hFFFF_FFFF); @(negedge clk);
        checks++; if (bus.wdata_o !== 32'd0) begin errors++; $display("FAIL slt got=%h exp=0", bus.wdata_o); end
        bus.hi_i = 32'h11; bus.mem_whilo_i = 1'b1; bus.mem_hi_i = 32'hA5; bus.wb_whilo_i = 1'b1; bus.wb_hi_i = 32'h5A;
        drive(OP_MFHI, S_MOV, 32'd0, 32'd0); @(negedge clk);
        checks++; if (bus.wdata_o !== 32'hA5) begin errors++; $display("FAIL mfhi_fwd got=%h exp=a5", bus.wdata_o); end
        bus.mem_whilo_i = 1'b0; bus.wb_whilo_i = 1'b0;
        drive(OP_MULTU, S_NOP, 32'hFFFF_FFFF, 32'd2); @(negedge clk);
        checks++; if ({bus.whilo_o, bus.hi_o, bus.lo_o} !== {1'b1, 32'd1, 32'hFFFF_FFFE}) begin errors++; $display("FAIL multu got=%b/%h/%h exp=1/1/fffffffe", bus.whilo_o, bus.hi_o, bus.lo_o); end
        drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b, hif, lof, ew, eh, el;
        logic        er, ewh;
        int          k;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, NOPS - 1);
            a = rand_operand(); b = rand_operand();
            bus.wd_i = 5'($urandom()); bus.wreg_i = 1'($urandom());
            bus.hi_i = $urandom(); bus.lo_i = $urandom();
            bus.mem_whilo_i = 1'($urandom()); bus.mem_hi_i = $urandom(); bus.mem_lo_i = $urandom();
            bus.wb_whilo_i = 1'($urandom()); bus.wb_hi_i = $urandom(); bus.wb_lo_i = $urandom();
            hif = bus.mem_whilo_i ? bus.mem_hi_i : (bus.wb_whilo_i ? bus.wb_hi_i : bus.hi_i);
            lof = bus.mem_whilo_i ? bus.mem_lo_i : (bus.wb_whilo_i ? bus.wb_lo_i : bus.lo_i);
            drive(op_tab[k], sel_tab[k], a, b);
            model(op_tab[k], a, b, bus.wreg_i, hif, lof, ew, er, ewh, eh, el);
            @(negedge clk);
            checks++; if (bus.wdata_o !== ew) begin errors++; $display("FAIL rand_wdata op=%h a=%h b=%h got=%h exp=%h", op_tab[k], a, b, bus.wdata_o, ew); end
            checks++; if (bus.wreg_o !== er) begin errors++; $display("FAIL rand_wreg op=%h a=%h b=%h got=%b exp=%b", op_tab[k], a, b, bus.wreg_o, er); end
            checks++; if (bus.wd_o !== bus.wd_i) begin errors++; $display("FAIL rand_wd op=%h got=%h exp=%h", op_tab[k], bus.wd_o, bus.wd_i); end
            checks++; if (bus.whilo_o !== ewh) begin errors++; $display("FAIL rand_whilo op=%h got=%b exp=%b", op_tab[k], bus.whilo_o, ewh); end
            checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL rand_stall op=%h got=%b exp=0", op_tab[k], bus.stallreq_o); end
            if (ewh) begin
                checks++; if ({bus.hi_o, bus.lo_o} !== {eh, el}) begin errors++; $display("FAIL rand_hilo op=%h a=%h b=%h got=%h/%h exp=%h/%h", op_tab[k], a, b, bus.hi_o, bus.lo_o, eh, el); end
            end
        end
        bus.mem_whilo_i = 1'b0; bus.wb_whilo_i = 1'b0;
        drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask

`ifdef EX_DIV_EN
    task automatic test_div();
        logic [7:0]  ops [6] = '{OP_DIV, OP_DIVU, OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'd5, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFF7};
        logic [31:0] bs  [6] = '{32'd2, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        int stalls; bit done; logic wh; logic [31:0] hi, lo, eq, er;
        for (int i = 0; i < 6; i++) begin
            issue_div(ops[i], as[i], bs[i], stalls, done, wh, hi, lo);
            div_model(ops[i] == OP_DIV, as[i], bs[i], eq, er);
            checks++; if (!done) begin errors++; $display("FAIL div_timeout case=%0d stalls=%0d", i, stalls); end
            checks++; if (stalls != ((bs[i] == 32'd0) ? 1 : 33)) begin errors++; $display("FAIL div_stalls case=%0d got=%0d exp=%0d", i, stalls, (bs[i] == 32'd0) ? 1 : 33); end
            checks++; if ({wh, hi, lo} !== {1'b1, er, eq}) begin errors++; $display("FAIL div_result case=%0d got=%b/%h/%h exp=1/%h/%h", i, wh, hi, lo, er, eq); end
        end
        @(posedge clk); #1; drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        int stalls; bit done; logic wh; logic [31:0] a, b, hi, lo, eq, er; logic [7:0] op;
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
            a = rand_operand(); b = ($urandom_range(0, 4) == 0) ? 32'd0 : rand_operand();
            issue_div(op, a, b, stalls, done, wh, hi, lo);
            div_model(op == OP_DIV, a, b, eq, er);
            checks++; if (!done || stalls != ((b == 32'd0) ? 1 : 33)) begin errors++; $display("FAIL b2b_stalls op=%h a=%h b=%h got=%0d done=%b", op, a, b, stalls, done); end
            checks++; if ({wh, hi, lo} !== {1'b1, er, eq}) begin errors++; $display("FAIL b2b_result op=%h a=%h b=%h got=%h/%h exp=%h/%h", op, a, b, hi, lo, er, eq); end
        end
        @(posedge clk); #1; drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask

    task automatic test_div_reset();
        int  stalls;
        bit  done;
        @(posedge clk); #1;
        drive(OP_DIVU, S_NOP, 32'd1000, 32'd3);
        stalls = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (bus.stallreq_o) stalls++;
        end
        checks++; if (stalls != 11) begin errors++; $display("FAIL rst_prefix_stalls got=%0d exp=11", stalls); end
        rst = 1'b1;
        drive(OP_DIVU, S_NOP, 32'd100, 32'd7);
        #1;
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", bus.stallreq_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        stalls = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.stallreq_o) stalls++;
            else begin
                done = 1'b1;
                checks++; if ({bus.whilo_o, bus.hi_o, bus.lo_o} !== {1'b1, 32'd2, 32'd14}) begin errors++; $display("FAIL rst_reissue_result got=%b/%h/%h exp=1/2/e", bus.whilo_o, bus.hi_o, bus.lo_o); end
            end
        end
        checks++; if (!done || stalls != 33) begin errors++; $display("FAIL rst_reissue_stalls got=%0d done=%b exp=33", stalls, done); end
        @(posedge clk); #1; drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask

    task automatic test_abort();
        int stalls; bit done; logic wh; logic [31:0] hi, lo;
        @(posedge clk); #1;
        drive(OP_DIV, S_NOP, 32'd50, 32'd3);
        for (int c = 0; c < 6; c++) @(negedge clk);
        drive(OP_ADDU, S_AR, 32'd3, 32'd4);
        #1;
        checks++; if ({bus.stallreq_o, bus.whilo_o, bus.wdata_o} !== {2'b00, 32'd7}) begin errors++; $display("FAIL abort_outputs got=%b/%b/%h exp=0/0/7", bus.stallreq_o, bus.whilo_o, bus.wdata_o); end
        issue_div(OP_DIVU, 32'd9, 32'd2, stalls, done, wh, hi, lo);
        checks++; if (!done || stalls != 33) begin errors++; $display("FAIL abort_restart_stalls got=%0d done=%b exp=33", stalls, done); end
        checks++; if ({wh, hi, lo} !== {1'b1, 32'd1, 32'd4}) begin errors++; $display("FAIL abort_restart_result got=%b/%h/%h exp=1/1/4", wh, hi, lo); end
        @(posedge clk); #1; drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask
`else
    task automatic test_div_disabled();
        drive(OP_DIV, S_NOP, 32'hFFFF_FFF9, 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({bus.stallreq_o, bus.whilo_o} !== 2'b00) begin errors++; $display("FAIL nodiv_div cyc=%0d got=%b/%b exp=0/0", c, bus.stallreq_o, bus.whilo_o); end
        end
        drive(OP_DIVU, S_NOP, 32'd5, 32'd0);
        @(negedge clk);
        checks++; if ({bus.stallreq_o, bus.whilo_o} !== 2'b00) begin errors++; $display("FAIL nodiv_divu got=%b/%b exp=0/0", bus.stallreq_o, bus.whilo_o); end
        drive(8'd0, S_NOP, 32'd0, 32'd0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(8'd0, S_NOP, 32'd0, 32'd0);
        bus.wd_i = 5'd0; bus.wreg_i = 1'b0; bus.hi_i = 32'd0; bus.lo_i = 32'd0;
        bus.mem_whilo_i = 1'b0; bus.mem_hi_i = 32'd0; bus.mem_lo_i = 32'd0;
        bus.wb_whilo_i = 1'b0; bus.wb_hi_i = 32'd0; bus.wb_lo_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random_alu();
`ifdef EX_DIV_EN
        test_div();
        test_back_to_back();
        test_div_reset();
        test_abort();
`else
        test_div_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
